// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, host command opcodes, sequencer states and the TAP next-state function.
package jtag_pkg;
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;
  typedef enum logic [1:0] {OP_RESET, OP_SCAN_IR, OP_SCAN_DR, OP_IDLE} cmd_op_e;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WALK_IN, S_SHIFT, S_WALK_OUT, S_DWELL, S_RESP} seq_state_e;
  localparam int INIT_ONES = 5;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:    tap_next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    tap_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: tap_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: tap_next = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: tap_next = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: tap_next = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: tap_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: tap_next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: tap_next = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: tap_next = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: tap_next = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: tap_next = tms ? TAP_SEL_DR : TAP_RTI;
      default:    tap_next = TAP_TLR;
    endcase
  endfunction
endpackage

// File: rtl/tap_state_mirror.sv
// tap_state_mirror: tracks a TAP controller's state from the TMS it is fed, one step per clock.
module tap_state_mirror
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state,
  output tap_state_e next_state
);
  assign next_state = tap_next(state, tms);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= TAP_TLR;
    else state <= next_state;
endmodule

// File: rtl/jtag_tap_host.sv
// jtag_tap_host: JTAG host sequencer driving TMS/TDI and collecting TDO in lockstep with a TAP on TCK.
// Build option JTAG_HOST_IDLE_DWELL_EN: hold Run-Test/Idle for IDLE_CYC edges after each scan.
module jtag_tap_host
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W = 6
`ifdef JTAG_HOST_IDLE_DWELL_EN
  , parameter int IDLE_CYC = 4
`endif
) (
  input  logic               TCK,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  localparam int IDX_W = $clog2(MAX_LEN);
  seq_state_e st, st_n;
  tap_state_e m, m_n;
  logic [LEN_W-1:0] cnt, cnt_n, len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [IDX_W-1:0] idx;
  logic [1:0] op_q;
  logic tms_d, tdi_d, rsp_d, len_ok, at_idle, scan_go;

  tap_state_mirror u_mirror (.clk(TCK), .rst(reset), .tms(TMS), .state(m), .next_state(m_n));

  assign cmd_ready = st == S_IDLE;
  assign len_ok = cmd_len != '0 && cmd_len <= LEN_W'(MAX_LEN);
  assign at_idle = m_n == TAP_RTI;
  assign scan_go = cmd_valid && (cmd_op == OP_SCAN_IR || cmd_op == OP_SCAN_DR) && len_ok;

  always_ff @(posedge TCK or posedge reset)
    if (reset) st <= S_INIT;
    else st <= st_n;

  // cnt: init/reset ones, walk-in steps, shift bits (N-1 down to 0), walk-out steps, dwell edges
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    case (st)
      S_INIT: begin
        cnt_n = cnt - LEN_W'(cnt != '0);
        st_n = at_idle ? S_IDLE : S_INIT;
      end
      S_IDLE: if (cmd_valid) begin
        st_n = cmd_op == OP_RESET ? S_INIT : scan_go ? S_WALK_IN : S_RESP;
        cnt_n = cmd_op == OP_RESET ? LEN_W'(INIT_ONES - 1) : cmd_op == OP_SCAN_IR ? LEN_W'(2) : LEN_W'(1);
      end
      S_WALK_IN: begin
        st_n = cnt == '0 ? S_SHIFT : S_WALK_IN;
        cnt_n = cnt == '0 ? len_q - LEN_W'(1) : cnt - LEN_W'(1);
      end
      S_SHIFT: begin
        st_n = cnt == '0 ? S_WALK_OUT : S_SHIFT;
        cnt_n = cnt == '0 ? LEN_W'(1) : cnt - LEN_W'(1);
      end
      S_WALK_OUT: begin
        cnt_n = cnt - LEN_W'(cnt != '0);
`ifdef JTAG_HOST_IDLE_DWELL_EN
        if (at_idle) begin
          st_n = S_DWELL;
          cnt_n = LEN_W'(IDLE_CYC - 1);
        end
`else
        st_n = at_idle ? S_IDLE : S_WALK_OUT;
`endif
      end
`ifdef JTAG_HOST_IDLE_DWELL_EN
      S_DWELL: begin
        st_n = cnt == '0 ? S_IDLE : S_DWELL;
        cnt_n = cnt - LEN_W'(cnt != '0);
      end
`endif
      S_RESP: st_n = S_IDLE;
      default: st_n = S_INIT;
    endcase
  end

  // TMS is chosen one edge ahead: the TAP samples it on the following edge
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    rsp_d = 1'b0;
    case (st)
      S_INIT: begin
        tms_d = cnt != '0;
        rsp_d = at_idle && op_q == OP_RESET;
      end
      S_IDLE: tms_d = cmd_valid && (cmd_op == OP_RESET || scan_go);
      S_WALK_IN: tms_d = op_q == OP_SCAN_IR && cnt == LEN_W'(2);
      S_SHIFT: begin
        tms_d = cnt == '0;
        tdi_d = data_q[0];
      end
`ifdef JTAG_HOST_IDLE_DWELL_EN
      S_WALK_OUT: tms_d = cnt == LEN_W'(1);
      S_DWELL: rsp_d = cnt == '0;
`else
      S_WALK_OUT: begin
        tms_d = cnt == LEN_W'(1);
        rsp_d = at_idle;
      end
`endif
      S_RESP: rsp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge TCK or posedge reset)
    if (reset) begin
      TMS <= 1'b1;
      TDI <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      cnt <= LEN_W'(INIT_ONES);
      len_q <= '0;
      data_q <= '0;
      idx <= '0;
      op_q <= OP_IDLE;
    end else begin
      TMS <= tms_d;
      TDI <= tdi_d;
      rsp_valid <= rsp_d;
      cnt <= cnt_n;
      if (cmd_valid && cmd_ready) begin
        len_q <= cmd_len;
        data_q <= cmd_data;
        op_q <= cmd_op;
        rsp_data <= '0;
        idx <= '0;
      end else begin
        if (st == S_SHIFT) data_q <= data_q >> 1;
        if (m == TAP_SH_DR || m == TAP_SH_IR) begin
          rsp_data[idx] <= TDO;
          idx <= idx + IDX_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_jtag_tap_host.sv
// tb_jtag_tap_host: directed vector table plus hand-written init, back-to-back and mid-scan reset sequences.
module tb_jtag_tap_host;
  localparam int MAX_LEN = 32;
  localparam int LEN_W = 6;
  logic TCK = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, TMS, TDI, TDO;
  logic [MAX_LEN-1:0] rsp_data;
  logic [1:0] tdo_mode = 2'd0;
  logic tdo_r = 1'b0;
  int n_chk = 0, n_fail = 0;

  jtag_tap_host dut (
    .TCK(TCK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 TCK = ~TCK;
  // tdo_mode 2: one-bit TAP register delaying TDI by one edge; otherwise a constant
  always @(posedge TCK) tdo_r <= TDI;
  assign TDO = tdo_mode == 2'd2 ? tdo_r : tdo_mode[0];

  typedef struct {
    logic [1:0] op;
    logic [LEN_W-1:0] len;
    logic [31:0] data;
    logic [1:0] tdo;
    int edges;
    logic [31:0] rsp;
    logic [63:0] tms;
    logic [63:0] tdi;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 64 && !cmd_ready; k++) @(negedge TCK);
    check("ready wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic init_seq(input string tag);
    logic [7:0] tms_b, rdy_b, rv_b;
    tms_b = '0; rdy_b = '0; rv_b = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge TCK);
      tms_b[k] = TMS; rdy_b[k] = cmd_ready; rv_b[k] = rsp_valid;
    end
    check({tag, " init tms"}, 64'(tms_b), 64'h1F);
    check({tag, " init ready"}, 64'(rdy_b), 64'hC0);
    check({tag, " init rsp_valid"}, 64'(rv_b), 64'h0);
  endtask

  task automatic run_cmd(input vec_t v, output int edges, output logic [63:0] tms_b,
                         output logic [63:0] tdi_b, output logic rdy);
    tms_b = '0; tdi_b = '0; edges = -1; rdy = 1'b0;
    tdo_mode = v.tdo; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data; cmd_valid = 1'b1;
    for (int k = 0; k < 100 && edges < 0; k++) begin
      @(negedge TCK);
      if (k == 0) cmd_valid = 1'b0;
      if (k < 64) begin
        tms_b[k] = TMS;
        tdi_b[k] = TDI;
      end
      if (rsp_valid) begin
        edges = k;
        rdy = cmd_ready;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [63:0] tb_, db_;
    logic r;
    logic [9:0] tms_b, rv_b, rdy_b;
    vt[0] = '{2'd1, 6'd4,  32'h0000000A, 2'd0, 10, 32'h0,        64'h183,          64'hA0};
    vt[1] = '{2'd2, 6'd8,  32'h000000A5, 2'd2, 13, 32'h4A,       64'hC01,          64'h528};
    vt[2] = '{2'd2, 6'd32, 32'hDEADBEEF, 2'd2, 37, 32'hBD5B7DDE, 64'hC_0000_0001,  64'h6_F56D_F778};
    vt[3] = '{2'd1, 6'd5,  32'h00000015, 2'd1, 11, 32'h1F,       64'h303,          64'h150};
    vt[4] = '{2'd2, 6'd1,  32'h00000001, 2'd1, 6,  32'h1,        64'h19,           64'h8};
    vt[5] = '{2'd2, 6'd0,  32'hFFFFFFFF, 2'd1, 1,  32'h0,        64'h0,            64'h0};
    vt[6] = '{2'd2, 6'd33, 32'hFFFFFFFF, 2'd1, 1,  32'h0,        64'h0,            64'h0};
    vt[7] = '{2'd3, 6'd8,  32'hFFFFFFFF, 2'd1, 1,  32'h0,        64'h0,            64'h0};
    vt[8] = '{2'd0, 6'd8,  32'hFFFFFFFF, 2'd1, 6,  32'h0,        64'h1F,           64'h0};
    vt[9] = '{2'd1, 6'd32, 32'h12345678, 2'd1, 38, 32'hFFFFFFFF, 64'h18_0000_0003, 64'h1_2345_6780};

    repeat (3) @(negedge TCK);
    check("reset TMS", 64'(TMS), 64'd1);
    check("reset TDI", 64'(TDI), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    init_seq("power-up");

    for (int i = 0; i < 10; i++) begin
      wait_ready();
      run_cmd(vt[i], e, tb_, db_, r);
      check($sformatf("vec%0d edges", i), 64'(e), 64'(vt[i].edges));
      check($sformatf("vec%0d rsp_data", i), 64'(rsp_data), 64'(vt[i].rsp));
      check($sformatf("vec%0d tms", i), tb_, vt[i].tms);
      check($sformatf("vec%0d tdi", i), db_, vt[i].tdi);
      check($sformatf("vec%0d ready at rsp", i), 64'(r), 64'd1);
    end

    // back-to-back: DR len 1, IDLE held on cmd_valid and taken on the rsp_valid cycle
    wait_ready();
    tdo_mode = 2'd0; cmd_op = 2'd2; cmd_len = 6'd1; cmd_data = '0; cmd_valid = 1'b1;
    tms_b = '0; rv_b = '0; rdy_b = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge TCK);
      if (k == 0) cmd_op = 2'd3;
      if (k == 7) cmd_valid = 1'b0;
      tms_b[k] = TMS; rv_b[k] = rsp_valid; rdy_b[k] = cmd_ready;
    end
    check("b2b tms", 64'(tms_b), 64'h019);
    check("b2b rsp_valid", 64'(rv_b), 64'h140);
    check("b2b ready", 64'(rdy_b), 64'h340);

    // reset while the third DR bit is on TDI
    wait_ready();
    tdo_mode = 2'd1; cmd_op = 2'd2; cmd_len = 6'd16; cmd_data = 32'h0000FFFF; cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge TCK);
      if (k == 0) cmd_valid = 1'b0;
    end
    check("midscan TDI before reset", 64'(TDI), 64'd1);
    reset = 1'b1;
    #1;
    check("midscan TMS", 64'(TMS), 64'd1);
    check("midscan TDI", 64'(TDI), 64'd0);
    check("midscan rsp_valid", 64'(rsp_valid), 64'd0);
    check("midscan rsp_data", 64'(rsp_data), 64'd0);
    check("midscan cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge TCK);
    reset = 1'b0;
    init_seq("rerun");

    wait_ready();
    run_cmd(vt[1], e, tb_, db_, r);
    check("after rerun edges", 64'(e), 64'(vt[1].edges));
    check("after rerun rsp_data", 64'(rsp_data), 64'(vt[1].rsp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
